// File: rtl/sha256_pkg.sv
// Shared constants, state encoding and helpers for the SHA-256 message padder.
package sha256_pkg;

  localparam int unsigned BLOCK_BYTES = 64;
  localparam int unsigned LEN_OFFSET  = 56;
  localparam int unsigned BLOCK_W     = 512;
  localparam int unsigned IDX_W       = 7;
  localparam int unsigned CNT_W       = 64;
  localparam int unsigned SHIFT_W     = IDX_W + 3;

  // 0x80 terminator at byte 0; shifted right by 8*p to land at byte p
  localparam logic [BLOCK_W-1:0] PAD_MARK = {8'h80, {(BLOCK_W-8){1'b0}}};

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_EMIT,
    ST_EXTRA
  } pad_state_e;

  // Trailing length-only block, optionally opened by the terminator byte
  function automatic logic [BLOCK_W-1:0] tail_block(input logic mark,
                                                    input logic [CNT_W-1:0] cnt);
    tail_block = {(mark ? 8'h80 : 8'h00), {(BLOCK_W-8-CNT_W){1'b0}}, cnt};
  endfunction

endpackage

// File: rtl/sha256_pad_gen.sv
// Combinational padding of the final block: data mask, 0x80 marker and length field
// formed with whole-block shifts rather than byte iteration.
module sha256_pad_gen
  import sha256_pkg::*;
#(
  parameter int unsigned NB_W = 3
) (
  input  logic [IDX_W-1:0]   idx,
  input  logic [NB_W-1:0]    n,
  input  logic [CNT_W-1:0]   counter,
  input  logic [BLOCK_W-1:0] buffer,
  output logic [BLOCK_W-1:0] block_c,
  output logic               extra_c,
  output logic               wrap_c
);

  logic [IDX_W-1:0]   p;
  logic [SHIFT_W-1:0] sh;
  logic [BLOCK_W-1:0] keep;

  always_comb begin
    p       = idx + IDX_W'(n);
    sh      = {p, 3'b000};
    keep    = ~({BLOCK_W{1'b1}} >> sh);
    block_c = (buffer & keep) | (PAD_MARK >> sh);
    // Length fits behind the marker only when at least 8 bytes remain
    if (p <= IDX_W'(LEN_OFFSET - 1)) begin
      block_c[CNT_W-1:0] = counter;
    end
    extra_c = (p >= IDX_W'(LEN_OFFSET));
    wrap_c  = (p == IDX_W'(BLOCK_BYTES));
  end

endmodule

// File: rtl/sha256_block_padder.sv
// Packs byte-stream beats into 512-bit SHA-256 blocks with padding and length,
// emitting an extra length block when the tail does not fit.
module sha256_block_padder
  import sha256_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [8*DATA_BYTES-1:0]      in_data,
  input  logic                         in_last,
  input  logic [$clog2(DATA_BYTES):0]  in_nbytes,
  output logic                         blk_valid,
  input  logic                         blk_ready,
  output logic [BLOCK_W-1:0]           blk_data,
  output logic                         blk_first,
  output logic                         blk_last
);

  localparam int unsigned NB_W   = $clog2(DATA_BYTES) + 1;
  localparam int unsigned BEAT_W = 8 * DATA_BYTES;

  pad_state_e         state_q;
  logic [BLOCK_W-1:0] buf_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               extra_q;
  logic               wrap_q;
  logic               first_q;

  logic               accept;
  logic [NB_W-1:0]    n_eff;
  logic [IDX_W-1:0]   idx_full;
  logic [CNT_W-1:0]   cnt_full;
  logic [CNT_W-1:0]   cnt_last;
  logic [BLOCK_W-1:0] buf_merged;
  logic [BLOCK_W-1:0] pad_block;
  logic               pad_extra;
  logic               pad_wrap;
  logic               blk_done;
  logic [BLOCK_W-1:0] blk_next;

  // Beat placement, counter updates and block-completion detect
  always_comb begin
    accept     = in_valid & in_ready;
    n_eff      = (in_nbytes > NB_W'(DATA_BYTES)) ? NB_W'(DATA_BYTES) : in_nbytes;
    idx_full   = idx_q + IDX_W'(DATA_BYTES);
    cnt_full   = cnt_q + CNT_W'(BEAT_W);
    cnt_last   = cnt_q + CNT_W'({n_eff, 3'b000});
    buf_merged = buf_q | ({in_data, {(BLOCK_W-BEAT_W){1'b0}}} >> {idx_q, 3'b000});
    blk_done   = accept & (in_last | (idx_full == IDX_W'(BLOCK_BYTES)));
    blk_next   = in_last ? pad_block : buf_merged;
  end

  sha256_pad_gen #(
    .NB_W (NB_W)
  ) u_pad_gen (
    .idx     (idx_q),
    .n       (n_eff),
    .counter (cnt_last),
    .buffer  (buf_merged),
    .block_c (pad_block),
    .extra_c (pad_extra),
    .wrap_c  (pad_wrap)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      buf_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      extra_q   <= 1'b0;
      wrap_q    <= 1'b0;
      first_q   <= 1'b1;
      in_ready  <= 1'b0;
      blk_valid <= 1'b0;
      blk_data  <= '0;
      blk_first <= 1'b0;
      blk_last  <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          in_ready <= 1'b1;
          if (accept && !in_last) begin
            buf_q <= buf_merged;
            idx_q <= idx_full;
            cnt_q <= cnt_full;
          end
          if (accept && in_last) begin
            cnt_q   <= cnt_last;
            extra_q <= pad_extra;
            wrap_q  <= pad_wrap;
          end
          if (blk_done) begin
            state_q   <= ST_EMIT;
            in_ready  <= 1'b0;
            blk_valid <= 1'b1;
            blk_data  <= blk_next;
            blk_first <= first_q;
            blk_last  <= in_last & ~pad_extra;
            first_q   <= 1'b0;
          end
        end
        ST_EMIT: begin
          if (blk_ready) begin
            buf_q <= '0;
            idx_q <= '0;
            if (extra_q) begin
              // Same-cycle swap to the length block keeps blk_valid high
              state_q   <= ST_EXTRA;
              blk_data  <= tail_block(wrap_q, cnt_q);
              blk_first <= 1'b0;
              blk_last  <= 1'b1;
              extra_q   <= 1'b0;
            end else begin
              state_q   <= ST_LOAD;
              blk_valid <= 1'b0;
              in_ready  <= 1'b1;
              if (blk_last) begin
                cnt_q   <= '0;
                first_q <= 1'b1;
              end
            end
          end
        end
        ST_EXTRA: begin
          if (blk_ready) begin
            state_q   <= ST_LOAD;
            blk_valid <= 1'b0;
            in_ready  <= 1'b1;
            cnt_q     <= '0;
            first_q   <= 1'b1;
            wrap_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_padder.sv
// Directed bench: three padder instances (1, 4 and 8 byte beats) against hand-built blocks.
module tb_sha256_block_padder;

  logic         clk;
  logic         rst_n;
  logic [2:0]   in_valid;
  logic [2:0]   in_ready;
  logic [63:0]  in_data [3];
  logic [2:0]   in_last;
  logic [3:0]   in_nbytes [3];
  logic [2:0]   blk_valid;
  logic [2:0]   blk_ready;
  logic [511:0] blk_data [3];
  logic [2:0]   blk_first;
  logic [2:0]   blk_last;

  localparam logic [511:0] EXP_EMPTY = {8'h80, 504'd0};
  localparam logic [511:0] EXP_ABC   = {24'h616263, 8'h80, 416'd0, 64'h18};
  localparam logic [511:0] EXP_55    = 512'h000102030405060708090a0b0c0d0e0f_101112131415161718191a1b1c1d1e1f_202122232425262728292a2b2c2d2e2f_30313233343536_80_00000000000001b8;
  localparam logic [511:0] EXP_56A   = 512'h000102030405060708090a0b0c0d0e0f_101112131415161718191a1b1c1d1e1f_202122232425262728292a2b2c2d2e2f_3031323334353637_80_00000000000000;
  localparam logic [511:0] EXP_56B   = {448'd0, 64'h1c0};
  localparam logic [511:0] EXP_64A   = 512'h000102030405060708090a0b0c0d0e0f_101112131415161718191a1b1c1d1e1f_202122232425262728292a2b2c2d2e2f_303132333435363738393a3b3c3d3e3f;
  localparam logic [511:0] EXP_64B   = {8'h80, 440'd0, 64'h200};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned DB = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
    sha256_block_padder #(
      .DATA_BYTES (DB)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g][8*DB-1:0]),
      .in_last   (in_last[g]),
      .in_nbytes (in_nbytes[g][$clog2(DB):0]),
      .blk_valid (blk_valid[g]),
      .blk_ready (blk_ready[g]),
      .blk_data  (blk_data[g]),
      .blk_first (blk_first[g]),
      .blk_last  (blk_last[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_checks;
  int           n_fail;
  logic [7:0]   msg [64];
  int           got_cnt;
  logic [511:0] got_data [4];
  logic         got_first [4];
  logic         got_last [4];

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int dbw(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 4 : 8);
  endfunction

  task automatic set_pattern();
    for (int i = 0; i < 64; i++) msg[i] = 8'(i);
  endtask

  task automatic set_abc();
    set_pattern();
    msg[0] = 8'h61;
    msg[1] = 8'h62;
    msg[2] = 8'h63;
  endtask

  // MSB-first beat from msg; bytes beyond len are filler the DUT must mask
  function automatic logic [63:0] beat(input int k, input int pos, input int len);
    logic [63:0] d;
    d = '0;
    for (int j = 0; j < dbw(k); j++) begin
      d = (d << 8) | 64'((pos + j < len) ? msg[pos + j] : 8'hEE);
    end
    return d;
  endfunction

  task automatic put_beat(input int k, input logic [63:0] d, input logic last, input int n);
    for (int t = 0; t < 20 && !in_ready[k]; t++) tick();
    check_eq($sformatf("db%0d_in_ready_wait", dbw(k)), 512'(in_ready[k]), 512'(1));
    in_valid[k]  = 1'b1;
    in_data[k]   = d;
    in_last[k]   = last;
    in_nbytes[k] = 4'(n);
    tick();
    in_valid[k] = 1'b0;
    in_last[k]  = 1'b0;
  endtask

  task automatic drain(input int k);
    for (int t = 0; t < 4 && blk_valid[k]; t++) begin
      if (got_cnt < 4) begin
        got_data[got_cnt]  = blk_data[k];
        got_first[got_cnt] = blk_first[k];
        got_last[got_cnt]  = blk_last[k];
      end
      got_cnt++;
      blk_ready[k] = 1'b1;
      tick();
      blk_ready[k] = 1'b0;
    end
  endtask

  task automatic send_msg(input int k, input int len);
    int  pos;
    bit  done;
    pos     = 0;
    done    = 0;
    got_cnt = 0;
    while (!done) begin
      bit last;
      last = (pos + dbw(k) >= len);
      put_beat(k, beat(k, pos, len), last, last ? (len - pos) : 0);
      drain(k);
      pos += dbw(k);
      done = last;
    end
  endtask

  task automatic run_case(input int k, input int len, input string name,
                          input logic [511:0] e0, input logic [511:0] e1, input int ecnt);
    string pfx;
    pfx = $sformatf("db%0d_%s", dbw(k), name);
    send_msg(k, len);
    check_eq({pfx, "_nblk"}, 512'(got_cnt), 512'(ecnt));
    if (got_cnt > 0) begin
      check_eq({pfx, "_b0_data"}, got_data[0], e0);
      check_eq({pfx, "_b0_first"}, 512'(got_first[0]), 512'(1));
      check_eq({pfx, "_b0_last"}, 512'(got_last[0]), 512'(ecnt == 1));
    end
    if (ecnt == 2 && got_cnt > 1) begin
      check_eq({pfx, "_b1_data"}, got_data[1], e1);
      check_eq({pfx, "_b1_first"}, 512'(got_first[1]), 512'(0));
      check_eq({pfx, "_b1_last"}, 512'(got_last[1]), 512'(1));
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    blk_ready = '0;
    for (int k = 0; k < 3; k++) begin
      in_data[k]   = '0;
      in_nbytes[k] = '0;
    end
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("db%0d_rst_in_ready", dbw(k)), 512'(in_ready[k]), 512'(0));
      check_eq($sformatf("db%0d_rst_blk_valid", dbw(k)), 512'(blk_valid[k]), 512'(0));
      check_eq($sformatf("db%0d_rst_blk_data", dbw(k)), blk_data[k], 512'(0));
      check_eq($sformatf("db%0d_rst_flags", dbw(k)), 512'({blk_first[k], blk_last[k]}), 512'(0));
    end
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("db%0d_post_rst_in_ready", dbw(k)), 512'(in_ready[k]), 512'(1));
    end

    for (int k = 0; k < 3; k++) begin
      set_pattern();
      run_case(k, 0, "empty", EXP_EMPTY, '0, 1);
      set_abc();
      run_case(k, 3, "abc", EXP_ABC, '0, 1);
      set_pattern();
      run_case(k, 55, "len55", EXP_55, '0, 1);
      run_case(k, 56, "len56", EXP_56A, EXP_56B, 2);
      run_case(k, 64, "len64", EXP_64A, EXP_64B, 2);
    end

    // Downstream stall: block held, input blocked even with in_valid asserted
    set_abc();
    put_beat(1, beat(1, 0, 3), 1'b1, 3);
    check_eq("stall_valid_rise", 512'(blk_valid[1]), 512'(1));
    in_valid[1] = 1'b1;
    in_data[1]  = 64'hdeadbeef;
    for (int t = 0; t < 10; t++) begin
      tick();
      check_eq($sformatf("stall_valid_%0d", t), 512'(blk_valid[1]), 512'(1));
      check_eq($sformatf("stall_in_ready_%0d", t), 512'(in_ready[1]), 512'(0));
      check_eq($sformatf("stall_data_%0d", t), blk_data[1], EXP_ABC);
    end
    check_eq("stall_first_last", 512'({blk_first[1], blk_last[1]}), 512'(2'b11));
    in_valid[1]  = 1'b0;
    blk_ready[1] = 1'b1;
    tick();
    blk_ready[1] = 1'b0;
    check_eq("stall_release_valid", 512'(blk_valid[1]), 512'(0));
    check_eq("stall_release_ready", 512'(in_ready[1]), 512'(1));

    // Reset with db8 mid-message and db1 holding an undelivered block
    set_pattern();
    put_beat(2, beat(2, 0, 64), 1'b0, 0);
    put_beat(2, beat(2, 8, 64), 1'b0, 0);
    put_beat(0, 64'h61, 1'b1, 1);
    check_eq("mid_emit_valid", 512'(blk_valid[0]), 512'(1));
    rst_n = 1'b0;
    tick();
    check_eq("mid_rst_blk_valid0", 512'(blk_valid[0]), 512'(0));
    check_eq("mid_rst_in_ready2", 512'(in_ready[2]), 512'(0));
    rst_n = 1'b1;
    tick();
    check_eq("mid_rst_in_ready0", 512'(in_ready[0]), 512'(1));
    check_eq("mid_rst_no_block2", 512'(blk_valid[2]), 512'(0));
    set_abc();
    run_case(2, 3, "rst_abc", EXP_ABC, '0, 1);
    run_case(0, 3, "rst_abc", EXP_ABC, '0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
